// File: rtl/edf_arbiter.sv
// Earliest-deadline-first interrupt arbiter: a sequential scan picks the pending
// source with the smallest deadline, offers it to the hart and tracks claim/complete.
module edf_arbiter #(
  parameter int unsigned NSource = 8,
  parameter int unsigned TsWidth = 64,
  parameter int unsigned IdWidth = $clog2(NSource)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [63:0]                       mtime_i,
  input  logic [NSource-1:0]                ip_i,
  input  logic [NSource-1:0][TsWidth-1:0]   dl_i,
  output logic [NSource-1:0]                clr_o,
  output logic                              irq_o,
  output logic [IdWidth-1:0]                irq_id_o,
  output logic [TsWidth-1:0]                irq_dl_o,
  output logic                              late_o,
  input  logic                              claim_i,
  input  logic                              complete_i,
  input  logic [IdWidth-1:0]                complete_id_i
);

  localparam logic [1:0] SCAN    = 2'd0;
  localparam logic [1:0] NOTIFY  = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NSource - 1);

  logic [1:0]         state_q,    state_d;
  logic [IdWidth-1:0] idx_q,      idx_d;
  logic               cand_vld_q, cand_vld_d;
  logic [IdWidth-1:0] cand_id_q,  cand_id_d;
  logic [TsWidth-1:0] cand_dl_q,  cand_dl_d;
  logic               irq_q,      irq_d;
  logic [IdWidth-1:0] irq_id_q,   irq_id_d;
  logic [TsWidth-1:0] irq_dl_q,   irq_dl_d;
  logic [NSource-1:0] clr_q,      clr_d;

  logic               take;
  logic               scan_vld;
  logic [IdWidth-1:0] scan_id;
  logic [TsWidth-1:0] scan_dl;
  logic               withdrawn;
  logic               complete_hit;

  // Strict less-than keeps the earlier (lower index) candidate on equal deadlines.
  always_comb begin
    take         = ip_i[idx_q] && (!cand_vld_q || (dl_i[idx_q] < cand_dl_q));
    scan_vld     = cand_vld_q || take;
    scan_id      = take ? idx_q : cand_id_q;
    scan_dl      = take ? dl_i[idx_q] : cand_dl_q;
    withdrawn    = !ip_i[irq_id_q];
    complete_hit = complete_i && (complete_id_i == irq_id_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cand_vld_d = cand_vld_q;
    cand_id_d  = cand_id_q;
    cand_dl_d  = cand_dl_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    irq_dl_d   = irq_dl_q;
    clr_d      = '0;

    case (state_q)
      SCAN: begin
        cand_vld_d = scan_vld;
        cand_id_d  = scan_id;
        cand_dl_d  = scan_dl;
        if (idx_q == LastIdx) begin
          // Candidate register is cleared so the next pass always starts fresh.
          idx_d      = '0;
          cand_vld_d = 1'b0;
          if (scan_vld) begin
            state_d  = NOTIFY;
            irq_d    = 1'b1;
            irq_id_d = scan_id;
            irq_dl_d = scan_dl;
          end
        end else begin
          idx_d = idx_q + IdWidth'(1);
        end
      end

      NOTIFY: begin
        // A claim beats a simultaneous withdrawal.
        if (claim_i) begin
          clr_d[irq_id_q] = 1'b1;
          irq_d           = 1'b0;
          state_d         = SERVICE;
        end else if (withdrawn) begin
          irq_d   = 1'b0;
          state_d = SCAN;
        end
      end

      SERVICE: begin
        if (complete_hit) begin
          state_d = SCAN;
        end
      end

      default: begin
        state_d    = SCAN;
        idx_d      = '0;
        cand_vld_d = 1'b0;
        irq_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SCAN;
      idx_q      <= '0;
      cand_vld_q <= 1'b0;
      cand_id_q  <= '0;
      cand_dl_q  <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      irq_dl_q   <= '0;
      clr_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cand_vld_q <= cand_vld_d;
      cand_id_q  <= cand_id_d;
      cand_dl_q  <= cand_dl_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      irq_dl_q   <= irq_dl_d;
      clr_q      <= clr_d;
    end
  end

  assign clr_o    = clr_q;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;
  assign irq_dl_o = irq_dl_q;

  // Lateness follows mtime directly while an offer is outstanding.
  assign late_o = (state_q == NOTIFY) && (irq_dl_q < mtime_i[TsWidth-1:0]);

endmodule

// File: tb/tb_edf_arbiter.sv
// Bench for edf_arbiter: directed scenarios plus random traffic, checked every
// cycle against a pass-based behavioural model.
module tb_edf_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned TW = 64;
  localparam int unsigned IW = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [63:0]           mtime = '0;
  logic [N-1:0]          ip = '0;
  logic [N-1:0][TW-1:0]  dl = '0;
  logic [N-1:0]          clr;
  logic                  irq;
  logic [IW-1:0]         irq_id;
  logic [TW-1:0]         irq_dl;
  logic                  late;
  logic                  claim = 1'b0;
  logic                  complete = 1'b0;
  logic [IW-1:0]         complete_id = '0;

  int n_vec = 0;
  int n_err = 0;

  edf_arbiter #(.NSource(N), .TsWidth(TW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mtime_i       (mtime),
    .ip_i          (ip),
    .dl_i          (dl),
    .clr_o         (clr),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .irq_dl_o      (irq_dl),
    .late_o        (late),
    .claim_i       (claim),
    .complete_i    (complete),
    .complete_id_i (complete_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = scanning, 1 = offer outstanding, 2 = claimed and in service.
  int              m_mode = 0;
  int              m_pos = 0;
  logic            samp_ip [N];
  logic [TW-1:0]   samp_dl [N];
  logic            e_irq = 1'b0;
  logic [IW-1:0]   e_id = '0;
  logic [TW-1:0]   e_dl = '0;
  logic [N-1:0]    e_clr = '0;

  // Winner of a completed pass: smallest sampled deadline, lowest index among equals.
  task automatic pick(output bit found, output int win);
    logic [TW-1:0] best;
    found = 1'b0;
    win   = 0;
    best  = '1;
    for (int i = 0; i < N; i++)
      if (samp_ip[i] && (!found || samp_dl[i] < best)) begin
        best  = samp_dl[i];
        found = 1'b1;
      end
    for (int i = N - 1; i >= 0; i--)
      if (samp_ip[i] && samp_dl[i] == best && found) win = i;
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit found;
    int win;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0;
      e_irq = 1'b0; e_id = '0; e_dl = '0; e_clr = '0;
    end else begin
      e_clr = '0;
      case (m_mode)
        0: begin
          samp_ip[m_pos] = ip[m_pos];
          samp_dl[m_pos] = dl[m_pos];
          if (m_pos == N - 1) begin
            m_pos = 0;
            pick(found, win);
            if (found) begin
              m_mode = 1; e_irq = 1'b1;
              e_id = IW'(win); e_dl = samp_dl[win];
            end
          end else begin
            m_pos++;
          end
        end
        1: begin
          if (claim) begin
            e_clr[e_id] = 1'b1; e_irq = 1'b0; m_mode = 2;
          end else if (!ip[e_id]) begin
            e_irq = 1'b0; m_mode = 0; m_pos = 0;
          end
        end
        default: begin
          if (complete && complete_id == e_id) begin
            m_mode = 0; m_pos = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("irq_o", 64'(irq), 64'(e_irq));
    check("irq_id_o", 64'(irq_id), 64'(e_id));
    check("irq_dl_o", irq_dl, e_dl);
    check("clr_o", 64'(clr), 64'(e_clr));
    check("late_o", 64'(late), 64'((m_mode == 1) && (e_dl < mtime)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; claim = 1'b0; complete = 1'b0; ip = '0; dl = '0; mtime = '0;
    tick();
    tick();
  endtask

  task automatic wait_irq(input string name, input int budget, output int cyc);
    cyc = 0;
    while (!irq && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!irq) check({name, "_timeout"}, 64'(cyc), 64'(budget + 1));
  endtask

  initial begin
    int cyc;
    int hi;

    // Idle sources never raise an interrupt.
    hold_reset();
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (irq || clr != 0) hi++;
    end
    check("idle_activity", 64'(hi), 64'd0);

    // Earliest deadline wins; claim pulses the matching clear.
    hold_reset();
    ip[2] = 1'b1; dl[2] = 64'd500;
    ip[5] = 1'b1; dl[5] = 64'd300;
    rst_n = 1'b1;
    wait_irq("edf", 20, cyc);
    check("edf_latency", 64'(cyc), 64'd8);
    check("edf_id", 64'(irq_id), 64'd5);
    check("edf_dl", irq_dl, 64'd300);
    claim = 1'b1;
    tick();
    claim = 1'b0; ip[5] = 1'b0;
    check("edf_clr", 64'(clr), 64'h20);
    check("edf_irq_drop", 64'(irq), 64'd0);
    tick();
    check("edf_clr_once", 64'(clr), 64'd0);

    // Tie goes to lower index; mismatched completion ignored.
    hold_reset();
    ip[1] = 1'b1; dl[1] = 64'd100;
    ip[6] = 1'b1; dl[6] = 64'd100;
    rst_n = 1'b1;
    wait_irq("tie", 20, cyc);
    check("tie_id", 64'(irq_id), 64'd1);
    claim = 1'b1;
    tick();
    claim = 1'b0; ip[1] = 1'b0;
    complete = 1'b1; complete_id = 3'd6;
    tick();
    complete = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("tie_wrong_complete", 64'(irq), 64'd0);
    complete = 1'b1; complete_id = 3'd1;
    tick();
    complete = 1'b0;
    wait_irq("tie_next", 20, cyc);
    check("tie_next_latency", 64'(cyc), 64'd8);
    check("tie_next_id", 64'(irq_id), 64'd6);

    // Lateness tracks mtime while offered.
    hold_reset();
    ip[3] = 1'b1; dl[3] = 64'd50; mtime = 64'd49;
    rst_n = 1'b1;
    wait_irq("late", 20, cyc);
    check("late_before", 64'(late), 64'd0);
    mtime = 64'd51;
    #1;
    check("late_after", 64'(late), 64'd1);
    check("late_irq_held", 64'(irq), 64'd1);

    // Withdrawal drops the offer silently; claim wins over a same-cycle withdrawal.
    hold_reset();
    ip[4] = 1'b1; dl[4] = 64'd7;
    rst_n = 1'b1;
    wait_irq("wd", 20, cyc);
    check("wd_id", 64'(irq_id), 64'd4);
    ip[4] = 1'b0;
    tick();
    check("wd_irq", 64'(irq), 64'd0);
    check("wd_clr", 64'(clr), 64'd0);
    ip[4] = 1'b1;
    wait_irq("wd2", 20, cyc);
    ip[4] = 1'b0; claim = 1'b1;
    tick();
    claim = 1'b0;
    check("wd_claim_clr", 64'(clr), 64'h10);

    // Reset during service clears everything at once and restarts a full pass.
    hold_reset();
    ip[0] = 1'b1; dl[0] = 64'd9; mtime = 64'd100;
    rst_n = 1'b1;
    wait_irq("rst", 20, cyc);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {irq_dl[31:0], 24'(irq_id), clr, late, irq}, 64'd0);
    #1;
    tick();
    rst_n = 1'b1;
    wait_irq("rst_pass", 20, cyc);
    check("rst_pass_latency", 64'(cyc), 64'd8);

    // Random traffic against the model.
    hold_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3) == 0) ip = N'($urandom & $urandom);
      dl[$urandom_range(N - 1)] = 64'($urandom_range(40));
      mtime = mtime + 64'($urandom_range(2));
      if (mtime > 64'd45) mtime = '0;
      claim = ($urandom_range(3) == 0);
      complete = ($urandom_range(2) == 0);
      complete_id = ($urandom_range(1) == 0) ? e_id : IW'($urandom_range(N - 1));
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    claim = 1'b0; complete = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/edf_arbiter.md
EDF_ARBITER -- requirements
Module: edf_arbiter

Interface
REQ-001 SHALL have parameter NSource, default 8, number of interrupt sources (2..64).
REQ-002 SHALL have parameter TsWidth, default 64, deadline width in bits.
REQ-003 SHALL have parameter IdWidth, default $clog2(NSource), source-id width.
REQ-004 SHALL have port clk_i  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mtime_i  input  64  current machine time.
REQ-007 SHALL have port ip_i  input  NSource  per-source pending flag from gateway cells.
REQ-008 SHALL have port dl_i  input  NSource x TsWidth  per-source absolute deadline from gateway cells.
REQ-009 SHALL have port clr_o  output  NSource  one-cycle pending-clear pulse back to the claimed source's gateway.
REQ-010 SHALL have port irq_o  output  1  interrupt request to hart.
REQ-011 SHALL have port irq_id_o  output  IdWidth  id of the offered source.
REQ-012 SHALL have port irq_dl_o  output  TsWidth  deadline of the offered source.
REQ-013 SHALL have port late_o  output  1  offered deadline already expired.
REQ-014 SHALL have port claim_i  input  1  hart claims the offered interrupt.
REQ-015 SHALL have port complete_i  input  1  hart signals handler completion.
REQ-016 SHALL have port complete_id_i  input  IdWidth  id being completed.

Function
REQ-017 SHALL implement states SCAN, NOTIFY, SERVICE.
REQ-018 SCAN SHALL examine one source per cycle, index 0..NSource-1 ascending; a full pass takes NSource cycles.
REQ-019 During a pass, a source SHALL become the candidate if ip_i[idx]=1 and (no candidate yet or dl_i[idx] < candidate deadline, unsigned).
REQ-020 Ties SHALL keep the earlier candidate (lowest index wins).
REQ-021 Candidate deadline SHALL be captured from dl_i when selected; later dl_i changes do not affect it.
REQ-022 At end of pass (idx=NSource-1 examined): candidate exists -> NOTIFY next cycle; otherwise restart pass at idx 0 next cycle.
REQ-023 In NOTIFY: irq_o=1, irq_id_o/irq_dl_o hold candidate; outputs stable until leaving NOTIFY.
REQ-024 late_o SHALL be 1 in NOTIFY when candidate deadline < mtime_i[TsWidth-1:0] (unsigned), combinational on mtime_i; 0 otherwise.
REQ-025 In NOTIFY, claim_i=1 SHALL: assert clr_o[irq_id_o] for exactly the next cycle, deassert irq_o next cycle, enter SERVICE.
REQ-026 In NOTIFY, if ip_i[candidate]=0 and claim_i=0 (withdrawn): irq_o drops next cycle, no clr_o, restart SCAN at idx 0.
REQ-027 Withdrawal and claim in same cycle: claim SHALL win (REQ-025).
REQ-028 In SERVICE: irq_o=0; complete_i=1 with complete_id_i equal to claimed id -> SCAN at idx 0 next cycle.
REQ-029 complete_i with mismatched id, or complete_i outside SERVICE, SHALL be ignored.
REQ-030 claim_i outside NOTIFY SHALL be ignored; no clr_o generated.
REQ-031 At most one clr_o bit SHALL be high in any cycle; clr_o=0 in all cycles except per REQ-025.
REQ-032 No preemption: a new earlier deadline arriving during NOTIFY/SERVICE SHALL be considered only in the next SCAN pass.
REQ-033 irq_id_o/irq_dl_o SHALL hold last claimed values in SERVICE; 0 after reset until first NOTIFY.

Reset
REQ-034 Reset assertion SHALL asynchronously force: state SCAN, idx 0, no candidate, irq_o=0, clr_o=0, irq_id_o=0, irq_dl_o=0, late_o=0.
REQ-035 Reset mid-NOTIFY or mid-SERVICE SHALL discard the claim without any clr_o pulse; first pass starts the cycle after rst_ni rises.

Verification
REQ-036 NSource=8, ip_i=0 for 40 cycles -> irq_o stays 0, clr_o stays 0.
REQ-037 ip_i[2]=1 dl=500, ip_i[5]=1 dl=300 -> irq_o within 9 cycles, irq_id_o=5, irq_dl_o=300; claim_i -> clr_o=8'b0010_0000 one cycle, irq_o=0.
REQ-038 ip_i[1], ip_i[6] both dl=100 -> irq_id_o=1; complete_i id=6 in SERVICE ignored, id=1 -> new scan, offers 6.
REQ-039 Offer id=3 dl=50, mtime_i=49 -> late_o=0; mtime_i=51 -> late_o=1, irq_o still 1.
REQ-040 Offer id=4, drop ip_i[4] without claim -> irq_o=0 next cycle, clr_o never pulses; same cycle with claim_i=1 -> clr_o[4] pulses.
REQ-041 rst_ni low in SERVICE for 1 cycle -> all outputs 0 immediately, irq_o re-asserts only after a full new pass.
